fmul_pipe: RTL
==============

Name: fmul_pipe

Overview:
- Parametrised, pipelined IEEE-754 multiplier; successor to the single-cycle combinational FPU multiplier.
- Adds a configurable pipeline depth, valid/ready handshakes with full-pipeline stall, and a pass-through tag.
- Adds round-to-nearest-even over the full product, canonical NaN / invalid handling, and an exception flag bundle.
- Sits between the FPU issue logic and FPU writeback; the default configuration is binary32.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored mantissa width (hidden bit excluded)
STAGES, 3, pipeline registers from input to output (1..4)
TAG_W, 6, width of the opaque tag carried alongside each operation

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operands present
in_ready  out  1  block accepts operands this cycle
s  in  EXP_W+MAN_W+1  operand A
t  in  EXP_W+MAN_W+1  operand B
in_tag  in  TAG_W  tag returned with the result
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result
d  out  EXP_W+MAN_W+1  product
out_tag  out  TAG_W  tag of the result
overflow  out  1  result rounded to infinity
underflow  out  1  nonzero result flushed to zero
invalid  out  1  inf*0 or signalling NaN input

Behaviour:
- Reset is asynchronous on rstn low.
  - All stage valid bits clear; out_valid=0; d=0; out_tag=0; all flags 0.
  - in_ready is 1 while in reset-released idle.
- Pipeline advance enable: en = ~out_valid | out_ready.
  - in_ready = en.
  - An operation is accepted when in_valid & in_ready.
  - When en=0, every stage, including all tags and flags, holds.
- Latency is exactly STAGES cycles from acceptance to out_valid with no stall.
- Throughput is 1 operation per cycle. Bubbles propagate as valid=0.
- Output stability: d, out_tag and the flags hold stable while out_valid & ~out_ready.
- Stage split for STAGES=3:
  - S1: unpack, special-case classify, sign XOR, exponent sum.
  - S2: (MAN_W+1)x(MAN_W+1) product.
  - S3: normalise, round, pack.
- STAGES=1 collapses all three into one register. STAGES=2 merges S2 and S3. STAGES=4 splits the product into two halves.
- Denormal inputs (exp=0, man!=0) are treated as signed zero (flush-to-zero).
- Normalisation: if product bit 2*MAN_W+1 is set, shift right by 1 and increment the exponent.
- Rounding is round-to-nearest-even, using guard, round and sticky (OR of all remaining low bits).
  - Mantissa carry-out on rounding increments the exponent.
- Biased exponent: e = es + et - BIAS + carry, with BIAS = 2^(EXP_W-1)-1.
  - Computed in EXP_W+2 signed bits.
- e >= 2^EXP_W-1 after rounding: result is signed infinity; overflow=1.
- e <= 0: result is signed zero; underflow=1. No subnormal output is produced.
- Special-case priority, evaluated in order:
  1. Either input NaN: result is the quieted first NaN operand (s before t), with its sign kept. invalid=1 only if that NaN is signalling (top mantissa bit 0).
  2. inf*0 in either order: canonical NaN {0, all-ones exponent, 1, zeros}; invalid=1.
  3. Either input inf: signed infinity; no flags.
  4. Either input zero or denormal: signed zero; no flags.
- Flags are valid only with out_valid and are otherwise 0.
- Reset asserted mid-operation discards all in-flight operations; no result is emitted after release.

Test Plan:
- Basic product: 0x40000000*0x40400000 (2.0*3.0), out_ready=1 -> d=0x40C00000, out_valid exactly 3 cycles after acceptance, flags 0.
- Rounding: 0x3F800001*0x3F800001 -> d=0x3F800002. Also 0x3FC00000*0x3FC00000 -> 0x40100000 via the normalise-shift path.
- Overflow and underflow:
  - 0x7F000000*0x40000000 -> 0x7F800000, overflow=1.
  - 0x00800000*0x3F000000 -> 0x00000000, underflow=1.
  - 0x80800000*0x3F000000 -> 0x80000000, underflow=1.
- Specials:
  - 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000*0x40000000 -> 0xFF800000, no flags.
  - 0x7F800001*0x3F800000 -> 0x7FC00001, invalid=1.
  - 0x00000001*0x40000000 -> 0x00000000, no flags.
- Backpressure:
  - Stream 8 back-to-back ops with tags 0..7.
  - Hold out_ready=0 for 4 cycles mid-stream: in_ready=0 during the hold, out_valid and d stay stable.
  - All 8 results emerge in order with the correct tags and none are lost or duplicated.
- Reset mid-flight: pull rstn low asynchronously with 3 ops in flight -> out_valid=0 immediately, and no result appears in the 5 cycles after release.

Source files
------------

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 multiplier with valid/ready handshake,
// round-to-nearest-even, flush-to-zero inputs, canonical NaN handling,
// exception flags and a pass-through tag. The default configuration is binary32.
//
// Handshake: an operation transfers on the input side when in_valid & in_ready,
// and on the output side when out_valid & out_ready. The whole pipeline advances
// together on en = ~out_valid | out_ready (in_ready = en). While en is low every
// stage holds, so d, out_tag and the flags stay stable until they are consumed.
module fmul_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   s,
    input  logic [EXP_W+MAN_W:0]   t,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   d,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int PW = 2 * MAN_W + 2;          // full significand product width
    localparam int H  = (MAN_W + 1) / 2;        // split point for the two-part product

    localparam logic signed [EXP_W+1:0] BIAS   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EXP_W+1:0] EMAX   = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;

    // Per-operation bookkeeping carried through every stage
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             sign;
        logic [EXP_W+1:0] esum;      // es + et - BIAS, signed
        logic             special;   // result already decided by classification
        logic [W-1:0]     spec_res;
        logic             spec_inv;
    } meta_t;

    typedef struct packed {
        meta_t        m;
        logic [MAN_W:0] ma;
        logic [MAN_W:0] mb;
    } s1_t;

    typedef struct packed {
        meta_t        m;
        logic [PW-1:0] pp_lo;
        logic [PW-1:0] pp_hi;
    } h_t;

    typedef struct packed {
        meta_t        m;
        logic [PW-1:0] prod;
    } s2_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     d;
        logic             ov;
        logic             uf;
        logic             inv;
    } out_t;

    // Unpack, classify specials in priority order, sign XOR and exponent sum
    function automatic s1_t unpack(input logic v, input logic [TAG_W-1:0] tag,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        s1_t              r;
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [W-1:0]     nan_op;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        // exponent zero covers both true zero and flushed denormals
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        r            = '0;
        r.m.valid    = v;
        r.m.tag      = tag;
        r.m.sign     = a[W-1] ^ b[W-1];
        r.m.esum     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        r.ma         = {1'b1, fa};
        r.mb         = {1'b1, fb};
        nan_op       = a_nan ? a : b;
        if (a_nan | b_nan) begin
            r.m.special         = 1'b1;
            r.m.spec_res        = nan_op;
            r.m.spec_res[MAN_W-1] = 1'b1;
            r.m.spec_inv        = ~nan_op[MAN_W-1];
        end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
            r.m.special  = 1'b1;
            r.m.spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            r.m.spec_inv = 1'b1;
        end else if (a_inf | b_inf) begin
            r.m.special  = 1'b1;
            r.m.spec_res = {r.m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            r.m.special  = 1'b1;
            r.m.spec_res = {r.m.sign, {(W-1){1'b0}}};
        end
        return r;
    endfunction

    // Full significand product in one step
    function automatic s2_t mult(input s1_t x);
        s2_t r;
        r.m    = x.m;
        r.prod = {{(MAN_W+1){1'b0}}, x.ma} * {{(MAN_W+1){1'b0}}, x.mb};
        return r;
    endfunction

    // First half of a two-step product: partial products against each half of mb
    function automatic h_t half_mult(input s1_t x);
        h_t r;
        r.m     = x.m;
        r.pp_lo = {{(MAN_W+1){1'b0}}, x.ma} * {{(PW-H){1'b0}}, x.mb[H-1:0]};
        r.pp_hi = {{(MAN_W+1){1'b0}}, x.ma} * {{(PW-MAN_W-1+H){1'b0}}, x.mb[MAN_W:H]};
        return r;
    endfunction

    // Second half of a two-step product: align and sum the partial products
    function automatic s2_t combine(input h_t x);
        s2_t r;
        r.m    = x.m;
        r.prod = x.pp_lo + (x.pp_hi << H);
        return r;
    endfunction

    // Normalise, round to nearest even, range-check and pack
    function automatic out_t pack(input s2_t x);
        out_t                     r;
        logic [PW-1:0]            np;
        logic                     norm, g, rb, st, up, carry;
        logic [MAN_W:0]           mr;
        logic signed [EXP_W+1:0]  e;
        norm  = x.prod[PW-1];
        // put the leading one at the top bit in both cases
        np    = norm ? x.prod : (x.prod << 1);
        g     = np[MAN_W];
        rb    = np[MAN_W-1];
        st    = |np[MAN_W-2:0];
        up    = g & (rb | st | np[MAN_W+1]);
        mr    = {1'b0, np[PW-2:MAN_W+1]} + {{MAN_W{1'b0}}, up};
        carry = mr[MAN_W];
        e     = $signed(x.m.esum) + $signed({{(EXP_W+1){1'b0}}, norm})
              + $signed({{(EXP_W+1){1'b0}}, carry});
        r       = '0;
        r.valid = x.m.valid;
        r.tag   = x.m.tag;
        if (x.m.special) begin
            r.d   = x.m.spec_res;
            r.inv = x.m.spec_inv;
        end else if (e >= EMAX) begin
            r.d  = {x.m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r.ov = 1'b1;
        end else if (e <= E_ZERO) begin
            r.d  = {x.m.sign, {(W-1){1'b0}}};
            r.uf = 1'b1;
        end else begin
            r.d = {x.m.sign, e[EXP_W-1:0], mr[MAN_W-1:0]};
        end
        return r;
    endfunction

    logic en;
    out_t out_r;

    assign en        = ~out_r.valid | out_ready;
    assign in_ready  = en;
    assign out_valid = out_r.valid;
    assign d         = out_r.d;
    assign out_tag   = out_r.tag;
    assign overflow  = out_r.valid & out_r.ov;
    assign underflow = out_r.valid & out_r.uf;
    assign invalid   = out_r.valid & out_r.inv;

    generate
        if (STAGES <= 1) begin : g_one
            // Whole datapath in front of a single register
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   out_r <= '0;
                else if (en) out_r <= pack(mult(unpack(in_valid, in_tag, s, t)));
            end
        end else if (STAGES == 2) begin : g_two
            s1_t s1_r;
            // Classify stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   s1_r <= '0;
                else if (en) s1_r <= unpack(in_valid, in_tag, s, t);
            end
            // Multiply merged with normalise/round/pack
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   out_r <= '0;
                else if (en) out_r <= pack(mult(s1_r));
            end
        end else if (STAGES == 3) begin : g_three
            s1_t s1_r;
            s2_t s2_r;
            // Classify stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   s1_r <= '0;
                else if (en) s1_r <= unpack(in_valid, in_tag, s, t);
            end
            // Product stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   s2_r <= '0;
                else if (en) s2_r <= mult(s1_r);
            end
            // Normalise/round/pack stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   out_r <= '0;
                else if (en) out_r <= pack(s2_r);
            end
        end else begin : g_four
            s1_t s1_r;
            h_t  h_r;
            s2_t s2_r;
            // Classify stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   s1_r <= '0;
                else if (en) s1_r <= unpack(in_valid, in_tag, s, t);
            end
            // Partial products stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   h_r <= '0;
                else if (en) h_r <= half_mult(s1_r);
            end
            // Partial product sum stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   s2_r <= '0;
                else if (en) s2_r <= combine(h_r);
            end
            // Normalise/round/pack stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)   out_r <= '0;
                else if (en) out_r <= pack(s2_r);
            end
        end
    endgenerate

endmodule
